// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer: circular queue of (pc, instruction) pairs
// between fetch and decode, with fetch freeze and branch flush.
module if_id_buffer #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_instruction,
   output logic              in_ready,
   input  logic              out_freeze,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_instruction
);

   localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [DATA_W-1:0] pc_mem  [DEPTH];
   logic [DATA_W-1:0] ins_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;

   function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Ready and valid come from count alone, so freeze never loops back to fetch
   assign in_ready = (count < FULL);
   assign out_valid = (count != '0);
   assign push = in_valid & in_ready & ~flush;
   assign pop = out_valid & ~out_freeze & ~flush;

   assign out_pc = out_valid ? pc_mem[rd_ptr] : '0;
   assign out_instruction = out_valid ? ins_mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]  <= '0;
            ins_mem[i] <= '0;
         end
      end else if (push) begin
         pc_mem[wr_ptr]  <= in_pc;
         ins_mem[wr_ptr] <= in_instruction;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop) rd_ptr <= nxt(rd_ptr);
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: scenario tasks plus a negedge scoreboard
// that mirrors the expected queue contents.
module tb_if_id_buffer;

   localparam int DEPTH = 2;
   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] pc;
      logic [W-1:0] ins;
   } ent_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic [W-1:0] in_pc;
   logic [W-1:0] in_instruction;
   logic         in_ready;
   logic         out_freeze;
   logic         out_valid;
   logic [W-1:0] out_pc;
   logic [W-1:0] out_instruction;

   int total = 0;
   int bad = 0;
   ent_t q[$];
   logic [W-1:0] seen16;

   if_id_buffer #(.DEPTH(DEPTH), .DATA_W(W)) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .in_valid(in_valid),
      .in_pc(in_pc),
      .in_instruction(in_instruction),
      .in_ready(in_ready),
      .out_freeze(out_freeze),
      .out_valid(out_valid),
      .out_pc(out_pc),
      .out_instruction(out_instruction)
   );

   always #5 clk = ~clk;

   // Scoreboard: compare head against expected queue, then apply the
   // push/pop/flush that the upcoming rising edge will perform.
   always @(negedge clk) begin
      logic ev;
      logic er;
      logic [W-1:0] epc;
      logic [W-1:0] eins;
      if (!rst) begin
         q.delete();
      end else begin
         ev = (q.size() != 0);
         er = (q.size() < DEPTH);
         epc = ev ? q[0].pc : '0;
         eins = ev ? q[0].ins : '0;
         total++;
         if (out_valid !== ev) begin
            bad++;
            $display("FAIL sb_valid t=%0t got=%b exp=%b", $time, out_valid, ev);
         end
         total++;
         if (out_pc !== epc || out_instruction !== eins) begin
            bad++;
            $display("FAIL sb_head t=%0t got=%h/%h exp=%h/%h",
                     $time, out_pc, out_instruction, epc, eins);
         end
         total++;
         if (in_ready !== er) begin
            bad++;
            $display("FAIL sb_ready t=%0t got=%b exp=%b", $time, in_ready, er);
         end
         if (ev && !out_freeze && !flush && out_pc == 32'd16) seen16 = 32'd16;
         if (flush) begin
            q.delete();
         end else begin
            if (ev && !out_freeze) void'(q.pop_front());
            if (in_valid && er) q.push_back('{pc: in_pc, ins: in_instruction});
         end
      end
   end

   task automatic cyc(input logic v, input logic [W-1:0] pc,
                      input logic [W-1:0] ins, input logic frz,
                      input logic fl);
      in_valid = v;
      in_pc = pc;
      in_instruction = ins;
      out_freeze = frz;
      flush = fl;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] mk(input logic [W-1:0] pc);
      return pc ^ 32'hE3A0_0000;
   endfunction

   task automatic test_reset;
      rst = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      in_pc = '0;
      in_instruction = '0;
      out_freeze = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_hold got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
      end
      rst = 1'b1;
      cyc(0, 0, 0, 0, 0);
      total++;
      if ({out_valid, in_ready, out_pc, out_instruction} !== {1'b0, 1'b1, 64'd0}) begin
         bad++;
         $display("FAIL rst_idle got v=%b r=%b pc=%h ins=%h exp 0/1/0/0",
                  out_valid, in_ready, out_pc, out_instruction);
      end
   endtask

   task automatic test_streaming;
      logic [W-1:0] pcs [3];
      logic [W-1:0] ins [3];
      pcs = '{32'd4, 32'd8, 32'd12};
      ins = '{32'hE3A00001, 32'hE3A01002, 32'hE0802001};
      for (int i = 0; i < 3; i++) begin
         cyc(1, pcs[i], ins[i], 0, 0);
         total++;
         if (out_pc !== pcs[i] || out_instruction !== ins[i] || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stream%0d got pc=%h ins=%h r=%b exp pc=%h ins=%h r=1",
                     i, out_pc, out_instruction, in_ready, pcs[i], ins[i]);
         end
      end
      cyc(0, 0, 0, 0, 0);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL stream_drain got v=%b exp v=0", out_valid);
      end
   endtask

   task automatic test_fill;
      cyc(1, 4, mk(4), 1, 0);
      cyc(1, 8, mk(8), 1, 0);
      total++;
      if (in_ready !== 1'b0 || out_pc !== 32'd4) begin
         bad++;
         $display("FAIL fill_full got r=%b pc=%h exp r=0 pc=4", in_ready, out_pc);
      end
      repeat (3) cyc(1, 12, mk(12), 1, 0);
      total++;
      if (in_ready !== 1'b0 || out_pc !== 32'd4) begin
         bad++;
         $display("FAIL fill_hold got r=%b pc=%h exp r=0 pc=4", in_ready, out_pc);
      end
      cyc(1, 12, mk(12), 0, 0);
      total++;
      if (out_pc !== 32'd8) begin
         bad++;
         $display("FAIL fill_rel1 got pc=%h exp pc=8", out_pc);
      end
      cyc(1, 12, mk(12), 0, 0);
      total++;
      if (out_pc !== 32'd12 || out_instruction !== mk(12)) begin
         bad++;
         $display("FAIL fill_rel2 got pc=%h ins=%h exp pc=c ins=%h",
                  out_pc, out_instruction, mk(12));
      end
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] pc;
      cyc(1, 4, mk(4), 0, 0);
      for (int i = 0; i < 5; i++) begin
         pc = 32'd8 + 32'(4 * i);
         cyc(1, pc, mk(pc), 0, 0);
         total++;
         if (out_pc !== pc || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b%0d got pc=%h v=%b r=%b exp pc=%h v=1 r=1",
                     i, out_pc, out_valid, in_ready, pc);
         end
      end
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic test_flush;
      seen16 = '0;
      cyc(1, 40, mk(40), 1, 0);
      cyc(1, 44, mk(44), 1, 0);
      cyc(1, 16, mk(16), 1, 1);
      total++;
      if ({out_valid, in_ready, out_pc, out_instruction} !== {1'b0, 1'b1, 64'd0}) begin
         bad++;
         $display("FAIL flush_full got v=%b r=%b pc=%h ins=%h exp 0/1/0/0",
                  out_valid, in_ready, out_pc, out_instruction);
      end
      cyc(1, 100, mk(100), 0, 0);
      total++;
      if (out_pc !== 32'd100 || out_instruction !== mk(100)) begin
         bad++;
         $display("FAIL flush_next got pc=%h exp pc=64", out_pc);
      end
      cyc(0, 0, 0, 0, 0);
      total++;
      if (seen16 !== '0) begin
         bad++;
         $display("FAIL flush_drop got pc16 seen=%h exp none", seen16);
      end
   endtask

   task automatic test_async_reset;
      cyc(1, 4, mk(4), 1, 0);
      cyc(1, 8, mk(8), 1, 0);
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      total++;
      if ({out_valid, in_ready, out_pc} !== {1'b0, 1'b1, 32'd0}) begin
         bad++;
         $display("FAIL async_rst got v=%b r=%b pc=%h exp 0/1/0",
                  out_valid, in_ready, out_pc);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc(1, 4, mk(4), 0, 0);
      total++;
      if (out_pc !== 32'd4 || out_instruction !== mk(4) || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL async_after got pc=%h v=%b exp pc=4 v=1", out_pc, out_valid);
      end
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic test_random;
      logic [W-1:0] pc;
      pc = 32'h1000;
      for (int i = 0; i < 300; i++) begin
         cyc(1'($urandom_range(0, 3) != 0), pc, mk(pc) ^ 32'(i),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
         pc = pc + 32'd4;
      end
      cyc(0, 0, 0, 0, 1);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rand_end got v=%b exp v=0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_fill();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Decoupling buffer between the instruction fetch stage and the instruction decode stage of the ARM pipeline.
- Captures (pc, instruction) pairs produced by fetch and holds up to DEPTH of them in a circular queue.
- Presents the oldest entry to decode. Back-pressure drives fetch freeze; a taken branch flushes all held entries.

Parameters:
- DEPTH, 2, number of buffered entries; must be >= 2; any integer value, not required to be a power of two.
- DATA_W, 32, width of the pc field and the instruction field.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  branch taken (from the execute stage); discards all buffered entries.
- in_valid  input  1  fetch presents a valid pair this cycle.
- in_pc  input  DATA_W  PC+4 value produced by fetch.
- in_instruction  input  DATA_W  fetched instruction word.
- in_ready  output  1  buffer can accept a pair; fetch freeze = ~in_ready.
- out_freeze  input  1  decode stall (hazard); head entry is held.
- out_valid  output  1  head entry is valid.
- out_pc  output  DATA_W  pc of the head entry.
- out_instruction  output  DATA_W  instruction of the head entry.

Behaviour:
- State:
  - Storage arrays pc_mem[DEPTH] and ins_mem[DEPTH].
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits wide (minimum 1 bit).
  - count, $clog2(DEPTH+1) bits wide.
- Reset (rst=0, asynchronous, effective immediately):
  - count, wr_ptr, rd_ptr and all storage entries are set to 0.
  - out_valid=0, out_pc=0, out_instruction=0, in_ready=1.
- Definitions:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & ~out_freeze & ~flush.
- Combinational outputs, all derived from registered state only:
  - in_ready = (count < DEPTH). There is no combinational path from out_freeze, in_valid or flush to in_ready.
  - out_valid = (count != 0).
  - out_pc and out_instruction = pc_mem[rd_ptr] and ins_mem[rd_ptr] when count != 0; otherwise 0 (bubble/NOP).
- Latency: a pair pushed at edge N is visible on the outputs immediately after edge N when the buffer was empty. There is no same-cycle bypass from input to output.
- Push: write to storage at wr_ptr; wr_ptr advances by 1 and wraps from DEPTH-1 to 0.
- Pop: rd_ptr advances by 1 and wraps from DEPTH-1 to 0.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
- Full (count==DEPTH):
  - in_ready=0, so no push occurs even if a pop happens in the same cycle; no pass-through.
  - in_valid while full is ignored; fetch must hold its data because it is frozen.
- Empty (count==0): pop cannot occur; out_freeze has no effect.
- Flush:
  - At the next edge, count=0 and wr_ptr=rd_ptr=0.
  - Any pair presented in that same cycle is dropped.
  - Flush dominates push, pop and out_freeze.
  - Storage contents are not required to be cleared, but outputs read 0 because count=0.
- Reset asserted mid-operation: all state clears immediately regardless of clk; buffered entries are lost.
- Order is strictly FIFO; pc and instruction of an entry always travel together.
- No overflow or underflow is possible; count never exceeds DEPTH and never goes negative.

Test Plan:
1. Reset then idle: rst=0 for 2 cycles, then release -> out_valid=0, out_pc=0, out_instruction=0, in_ready=1.
2. Streaming: push (4, E3A00001), (8, E3A01002), (12, E0802001) on consecutive cycles with out_freeze=0 -> outputs show each pair one cycle after its push, in order; count never exceeds 1.
3. Fill and back-pressure: out_freeze=1, push pc=4 and pc=8 -> in_ready=0 after the second push; hold in_valid with pc=12 for 3 cycles -> no change. Release freeze -> outputs sequence 4, 8, 12.
4. Simultaneous push/pop at count=1, DEPTH=2: head pc=4, push pc=8, pop -> next cycle count=1, out_pc=8. Repeat 5 times to exercise pointer wrap.
5. Flush while full with in_valid=1 (pc=16) -> next cycle out_valid=0, out_pc=0, in_ready=1. Pc=16 is never output; a subsequent push of pc=100 appears next.
6. Asynchronous reset mid-burst with count=2: drive rst low between clock edges -> out_valid=0 immediately, before the next edge; after release, a fresh push of pc=4 is output correctly.
